protocol_decoder: RTL and testbench

PROTOCOL_DECODER -- requirements
Module: protocol_decoder

---
 rtl/protocol_decoder.sv | 183 ++++++++++++++++++
 tb/tb_protocol_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/protocol_decoder.sv
// Buffered three-protocol word decoder: FIFO_DEPTH-entry input FIFO feeding an IDLE/DECODE/OUTPUT FSM.
// Optional error-event counter enabled by defining PROTOCOL_DECODER_ERRCNT_EN.
module protocol_decoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enc_valid,
   input  logic [1:0]                    enc_proto,
   input  logic [7:0]                    enc_data,
   input  logic                          dec_ready,
   output logic                          dec_valid,
   output logic [7:0]                    dec_data,
   output logic [1:0]                    dec_proto,
   output logic                          busy,
   output logic                          proto_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [1:0]                    debug_state,
   output logic [7:0]                    err_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] PROTO_NONE = 2'b00;
   localparam logic [1:0] PROTO_A    = 2'b01;
   localparam logic [1:0] PROTO_B    = 2'b10;
   localparam logic [1:0] PROTO_C    = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DECODE = 2'b01,
      OUTPUT = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [9:0]          mem_q [FIFO_DEPTH];
   logic [9:0]          mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [1:0]          work_proto_q, work_proto_d;
   logic [7:0]          work_data_q, work_data_d;
   logic                dec_valid_q, dec_valid_d;
   logic [7:0]          dec_data_q, dec_data_d;
   logic [1:0]          dec_proto_q, dec_proto_d;
   logic                proto_err_q, proto_err_d;
   logic                overflow_q, overflow_d;

   logic                push_req, push, pop, full;
   logic [9:0]          head;

   // FIFO control: a pop only happens from IDLE, which frees a slot for a same-edge push.
   always_comb begin
      push_req    = enc_valid && (enc_proto != PROTO_NONE);
      full        = (count_q == FULL_CNT);
      pop         = (state_q == IDLE) && (count_q != '0);
      push        = push_req && (!full || pop);
      head        = mem_q[rd_ptr_q];
      proto_err_d = enc_valid && (enc_proto == PROTO_NONE);
      overflow_d  = push_req && !push;

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = {enc_proto, enc_data};
      end

      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      work_proto_d = work_proto_q;
      work_data_d  = work_data_q;
      dec_valid_d  = dec_valid_q;
      dec_data_d   = dec_data_q;
      dec_proto_d  = dec_proto_q;

      case (state_q)
         IDLE: begin
            if (pop) begin
               work_proto_d = head[9:8];
               work_data_d  = head[7:0];
               state_d      = DECODE;
            end
         end
         DECODE: begin
            case (work_proto_q)
               PROTO_A: dec_data_d = work_data_q - 8'd1;
               PROTO_B: dec_data_d = ~work_data_q;
               PROTO_C: dec_data_d = work_data_q ^ 8'hAA;
               default: dec_data_d = work_data_q;
            endcase
            dec_proto_d = work_proto_q;
            dec_valid_d = 1'b1;
            state_d     = OUTPUT;
         end
         OUTPUT: begin
            // Output registers hold until the downstream handshake completes.
            if (dec_ready) begin
               dec_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         work_proto_q <= '0;
         work_data_q  <= '0;
         dec_valid_q  <= 1'b0;
         dec_data_q   <= '0;
         dec_proto_q  <= '0;
         proto_err_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         work_proto_q <= work_proto_d;
         work_data_q  <= work_data_d;
         dec_valid_q  <= dec_valid_d;
         dec_data_q   <= dec_data_d;
         dec_proto_q  <= dec_proto_d;
         proto_err_q  <= proto_err_d;
         overflow_q   <= overflow_d;
      end
   end

`ifdef PROTOCOL_DECODER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Counted on the same edge the pulse is raised; coincident events add one.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((proto_err_d || overflow_d) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 8'h00;
`endif

   assign dec_valid   = dec_valid_q;
   assign dec_data    = dec_data_q;
   assign dec_proto   = dec_proto_q;
   assign proto_err   = proto_err_q;
   assign overflow    = overflow_q;
   assign fifo_count  = count_q;
   assign debug_state = state_q;
   assign busy        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_protocol_decoder.sv
// Scoreboard bench for protocol_decoder: directed words push expected {proto,data}; a negedge monitor pops on handshakes.
module tb_protocol_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       enc_valid;
   logic [1:0] enc_proto;
   logic [7:0] enc_data;
   logic       dec_ready;
   logic       dec_valid;
   logic [7:0] dec_data;
   logic [1:0] dec_proto;
   logic       busy;
   logic       proto_err;
   logic       overflow;
   logic [2:0] fifo_count;
   logic [1:0] debug_state;
   logic [7:0] err_count;

   logic [9:0] exp_q[$];
   int         checks_total = 0;
   int         checks_passed = 0;

   protocol_decoder #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_proto(enc_proto),
      .enc_data(enc_data), .dec_ready(dec_ready), .dec_valid(dec_valid),
      .dec_data(dec_data), .dec_proto(dec_proto), .busy(busy),
      .proto_err(proto_err), .overflow(overflow), .fifo_count(fifo_count),
      .debug_state(debug_state), .err_count(err_count)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: a handshake completes at the next posedge when valid && ready at the negedge.
   always @(negedge clk) begin
      if (!reset && dec_valid && dec_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {22'd0, dec_proto, dec_data}, 32'h3FF);
         end else begin
            check("dec_word", {22'd0, dec_proto, dec_data}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] p, input logic [7:0] d);
      enc_valid = 1'b1;
      enc_proto = p;
      enc_data  = d;
   endtask

   task automatic idle_in();
      enc_valid = 1'b0;
      enc_proto = 2'b00;
      enc_data  = 8'h00;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      tick();
      check(name, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      dec_ready = 1'b0;
      idle_in();

      // Reset state, with a word offered during reset that must be ignored
      drive(2'b01, 8'h33);
      tick();
      tick();
      check("rst_dec_valid", dec_valid, 0);
      check("rst_dec_data", dec_data, 0);
      check("rst_dec_proto", dec_proto, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_state", debug_state, 0);
      check("rst_busy", busy, 0);
      check("rst_proto_err", proto_err, 0);
      check("rst_overflow", overflow, 0);
      check("rst_err_count", err_count, 0);
      reset = 1'b0;
      idle_in();
      tick();
      check("rst_no_push", fifo_count, 0);

      // Latency: A/0x43 sampled at E gives 0x42 valid from E+2
      dec_ready = 1'b1;
      drive(2'b01, 8'h43);
      exp_q.push_back({2'b01, 8'h42});
      tick();
      idle_in();
      check("lat_e0_count", fifo_count, 1);
      check("lat_e0_busy", busy, 1);
      check("lat_e0_valid", dec_valid, 0);
      tick();
      check("lat_e1_state", debug_state, 2'b01);
      check("lat_e1_count", fifo_count, 0);
      check("lat_e1_valid", dec_valid, 0);
      tick();
      check("lat_e2_valid", dec_valid, 1);
      check("lat_e2_state", debug_state, 2'b10);
      tick();
      check("lat_e3_valid", dec_valid, 0);
      check("lat_e3_state", debug_state, 2'b00);
      check("lat_e3_busy", busy, 0);

      // Each protocol, including A wrap-around, back to back
      drive(2'b10, 8'hA5); exp_q.push_back({2'b10, 8'h5A}); tick();
      drive(2'b11, 8'h55); exp_q.push_back({2'b11, 8'hFF}); tick();
      drive(2'b01, 8'h00); exp_q.push_back({2'b01, 8'hFF}); tick();
      idle_in();
      wait_drain("drain_mix", 20);

      // Overflow: 6 words with dec_ready low, 6th dropped
      dec_ready = 1'b0;
      tick();
      drive(2'b01, 8'h10); exp_q.push_back({2'b01, 8'h0F}); tick();
      drive(2'b10, 8'h20); exp_q.push_back({2'b10, 8'hDF}); tick();
      drive(2'b11, 8'h30); exp_q.push_back({2'b11, 8'h9A}); tick();
      drive(2'b01, 8'h40); exp_q.push_back({2'b01, 8'h3F}); tick();
      drive(2'b10, 8'h50); exp_q.push_back({2'b10, 8'hAF}); tick();
      check("ovf_w5_overflow", overflow, 0);
      check("ovf_w5_count", fifo_count, 4);
      drive(2'b11, 8'h60); tick();
      idle_in();
      check("ovf_w6_overflow", overflow, 1);
      check("ovf_w6_count", fifo_count, 4);
      check("ovf_w6_state", debug_state, 2'b10);
      check("ovf_w6_valid", dec_valid, 1);
      check("ovf_w6_data", dec_data, 8'h0F);
      dec_ready = 1'b1;
      tick();
      check("ovf_pulse_end", overflow, 0);
      check("full_idle_state", debug_state, 2'b00);
      check("full_idle_count", fifo_count, 4);

      // Push and pop on the same edge while full
      drive(2'b01, 8'h7F); exp_q.push_back({2'b01, 8'h7E}); tick();
      idle_in();
      check("pushpop_count", fifo_count, 4);
      check("pushpop_overflow", overflow, 0);
      check("pushpop_state", debug_state, 2'b01);
      wait_drain("drain_ovf", 40);

      // Rejected tag 00
      do_reset();
      tick();
      drive(2'b00, 8'h12); tick();
      idle_in();
      check("perr_pulse", proto_err, 1);
      check("perr_count", fifo_count, 0);
`ifdef PROTOCOL_DECODER_ERRCNT_EN
      check("perr_err_count", err_count, 1);
`else
      check("perr_err_count", err_count, 0);
`endif
      tick();
      check("perr_pulse_end", proto_err, 0);
      check("perr_no_valid", dec_valid, 0);
      check("perr_state", debug_state, 2'b00);

      // Reset in OUTPUT with 3 words buffered discards everything
      dec_ready = 1'b0;
      drive(2'b01, 8'h01); tick();
      drive(2'b01, 8'h02); tick();
      drive(2'b01, 8'h03); tick();
      drive(2'b01, 8'h04); tick();
      idle_in();
      check("pre_rst_state", debug_state, 2'b10);
      check("pre_rst_count", fifo_count, 3);
      reset = 1'b1;
      tick();
      check("mid_rst_valid", dec_valid, 0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_state", debug_state, 0);
      check("mid_rst_busy", busy, 0);
      reset = 1'b0;
      dec_ready = 1'b1;
      repeat (6) tick();
      check("post_rst_idle", {30'd0, busy, dec_valid}, 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
